mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 27 ++
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit: the E-stage
//   Multiop encodings, the controller state enum and the default busy
//   latencies. The unit and anything that decodes Multiop import this
//   package, so the encodings live in exactly one place.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFLO  = 3'b110,
    OP_MFHI  = 3'b111
  } multiop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   MIPS-style HI/LO multiply/divide unit. An arithmetic op computes its
//   result immediately into pending registers, then models the latency of
//   an iterative unit by holding busy for MULT_CYCLES or DIV_CYCLES before
//   committing the pending result to HI/LO.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous reset, active low
//   Multiop  in   3   E-stage op code (see mult_div_unit_pkg)
//   start    in   1   one-cycle strobe for mult/multu/div/divu
//   A        in  32   rs operand
//   B        in  32   rt operand
//   busy     out  1   high while an operation is in flight
//   out      out 32   LO for mflo, HI for mfhi, otherwise 0
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  Multiop,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out
);

  multiop_e           op;
  state_e             state, next_state;
  logic [3:0]         count;
  logic [31:0]        hi, lo, hi_p, lo_p;
  logic [31:0]        hi_calc, lo_calc;
  logic               accept, complete;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_ovf;

  assign op = multiop_e'(Multiop);

  // Operand casting picks signed or unsigned arithmetic; both products are
  // formed at full 64-bit width so the upper half is exact.
  assign prod_s = 64'($signed(A)) * 64'($signed(B));
  assign prod_u = 64'(A) * 64'(B);
  assign quot_s = $signed(A) / $signed(B);
  assign rem_s  = $signed(A) % $signed(B);
  assign quot_u = A / B;
  assign rem_u  = A % B;

  // -2^31 / -1 does not fit; pin it to the architectural answer instead of
  // relying on whatever the divider wraps to.
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Result selection. A zero divisor re-latches the current HI/LO so the
  // completion edge leaves them unchanged.
  always_comb begin
    hi_calc = hi;
    lo_calc = lo;
    case (op)
      OP_MULT:  {hi_calc, lo_calc} = prod_s;
      OP_MULTU: {hi_calc, lo_calc} = prod_u;
      OP_DIV: begin
        if (B != 32'd0) begin
          if (div_ovf) begin
            hi_calc = 32'd0;
            lo_calc = 32'h8000_0000;
          end else begin
            hi_calc = rem_s;
            lo_calc = quot_s;
          end
        end
      end
      OP_DIVU: begin
        if (B != 32'd0) begin
          hi_calc = rem_u;
          lo_calc = quot_u;
        end
      end
      default: ;
    endcase
  end

  // Controller: accept a start in IDLE, finish when the counter sits at 1.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !Multiop[2]) begin
          accept     = 1'b1;
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (count == 4'd1) begin
          complete   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_p  <= 32'd0;
      lo_p  <= 32'd0;
    end else begin
      state <= next_state;

      if (accept) begin
        hi_p  <= hi_calc;
        lo_p  <= lo_calc;
        count <= Multiop[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (state == ST_BUSY) begin
        count <= count - 4'd1;
      end

      // Moves to HI/LO are only honoured while idle; the pipeline stalls
      // them during busy, so dropping them here is the safe fallback.
      if (complete) begin
        hi <= hi_p;
        lo <= lo_p;
      end else if (state == ST_IDLE) begin
        if (op == OP_MTHI) hi <= A;
        if (op == OP_MTLO) lo <= A;
      end
    end
  end

  assign busy = (state == ST_BUSY);

  always_comb begin
    out = 32'd0;
    if (op == OP_MFLO) out = lo;
    if (op == OP_MFHI) out = hi;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed bench for mult_div_unit. Arithmetic ops push their expected
//   {HI,LO} into a scoreboard queue when issued; the entry is popped and
//   compared against mfhi/mflo reads once busy drops. Expected values come
//   from a shift-add / long-division model on operand magnitudes.
module tb_mult_div_unit;

  localparam logic [2:0] C_MULT  = 3'b000;
  localparam logic [2:0] C_MULTU = 3'b001;
  localparam logic [2:0] C_DIV   = 3'b010;
  localparam logic [2:0] C_DIVU  = 3'b011;
  localparam logic [2:0] C_MTHI  = 3'b100;
  localparam logic [2:0] C_MTLO  = 3'b101;
  localparam logic [2:0] C_MFLO  = 3'b110;
  localparam logic [2:0] C_MFHI  = 3'b111;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  logic        clk;
  logic        reset;
  logic [2:0]  Multiop;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] out;

  result_t     sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          n_checks;
  int          n_errors;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .Multiop (Multiop),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic built from shift-add and restoring division.
  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < 32; i++)
      if (b[i]) acc = acc + ({32'd0, a} << i);
    return acc;
  endfunction

  function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
    logic [32:0] r;
    logic [31:0] q;
    r = 33'd0;
    q = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      r = {r[31:0], n[i]};
      if (r >= {1'b0, d}) begin
        r    = r - {1'b0, d};
        q[i] = 1'b1;
      end
    end
    return {r[31:0], q};
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic result_t model_result(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    result_t     r;
    logic [63:0] p;
    logic [63:0] qr;
    logic [31:0] q, rm;
    r.hi = model_hi;
    r.lo = model_lo;
    case (op)
      C_MULT: begin
        p = umul(mag(a), mag(b));
        if (a[31] ^ b[31]) p = ~p + 64'd1;
        r = p;
      end
      C_MULTU: r = umul(a, b);
      C_DIV: begin
        if (b != 32'd0) begin
          qr = udivmod(mag(a), mag(b));
          q  = qr[31:0];
          rm = qr[63:32];
          if (a[31] ^ b[31]) q = ~q + 32'd1;
          if (a[31]) rm = ~rm + 32'd1;
          r.hi = rm;
          r.lo = q;
        end
      end
      C_DIVU: begin
        if (b != 32'd0) begin
          qr   = udivmod(a, b);
          r.hi = qr[63:32];
          r.lo = qr[31:0];
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one op for one clock edge, then return the bus to a bubble.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic st);
    Multiop = op;
    A       = a;
    B       = b;
    start   = st;
    @(negedge clk);
    start   = 1'b0;
    Multiop = C_MULT;
  endtask

  task automatic read_reg(input logic [2:0] sel, output logic [31:0] val);
    Multiop = sel;
    start   = 1'b0;
    #1;
    val     = out;
    Multiop = C_MULT;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
    logic [31:0] v;
    read_reg(C_MFHI, v);
    checkOutput({tag, " HI"}, v, exp_hi);
    read_reg(C_MFLO, v);
    checkOutput({tag, " LO"}, v, exp_lo);
  endtask

  task automatic issue_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    sb_q.push_back(model_result(op, a, b));
    applyStimulus(op, a, b, 1'b1);
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    applyStimulus(op, a, 32'd0, 1'b0);
    if (op == C_MTHI) model_hi = a;
    if (op == C_MTLO) model_lo = a;
  endtask

  // Count remaining busy cycles (bounded), then retire one scoreboard entry.
  task automatic wait_complete(input string tag, input int exp_cycles);
    int      n;
    result_t r;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
    if (sb_q.size() == 0) begin
      checkOutput({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      r        = sb_q.pop_front();
      model_hi = r.hi;
      model_lo = r.lo;
      check_regs(tag, model_hi, model_lo);
    end
  endtask

  initial begin
    logic [31:0] v;
    n_checks = 0;
    n_errors = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset    = 1'b0;
    Multiop  = C_MULT;
    start    = 1'b0;
    A        = 32'd0;
    B        = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    check_regs("reset", 32'd0, 32'd0);

    // First start right on the first edge after release
    @(negedge clk);
    reset = 1'b1;
    issue_arith(C_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_complete("mult -1*2", 5);
    checkOutput("mult -1*2 const HI", model_hi, 32'hFFFF_FFFF);

    issue_arith(C_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_complete("multu", 5);

    issue_arith(C_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_complete("div -7/2", 10);

    issue_arith(C_DIVU, 32'd7, 32'd2);
    wait_complete("divu 7/2", 10);

    issue_arith(C_MULT, 32'h8765_4321, 32'h1234_5678);
    wait_complete("mult mixed", 5);

    // Moves to HI/LO
    move_to(C_MTHI, 32'h1234_5678);
    read_reg(C_MFHI, v);
    checkOutput("mthi then mfhi", v, 32'h1234_5678);
    move_to(C_MTHI, 32'h1111_1111);
    move_to(C_MTLO, 32'h2222_2222);
    check_regs("mthi/mtlo", model_hi, model_lo);

    // Divide by zero keeps HI/LO
    issue_arith(C_DIV, 32'd5, 32'd0);
    wait_complete("div by zero", 10);
    checkOutput("div by zero const LO", model_lo, 32'h2222_2222);

    // Signed overflow
    issue_arith(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_complete("div overflow", 10);

    // Non-read op codes give 0 on out; bubbles and start-less div do nothing
    Multiop = C_DIV;
    start   = 1'b0;
    #1;
    checkOutput("out for non-read op", out, 32'd0);
    @(negedge clk);
    Multiop = C_MULT;
    @(negedge clk);
    checkOutput("bubble busy", {31'd0, busy}, 32'd0);
    check_regs("bubble", model_hi, model_lo);

    // Busy mult: old LO visible, mtlo/start ignored, result intact
    issue_arith(C_MULT, 32'h0001_2345, 32'h0000_0100);
    read_reg(C_MFLO, v);
    checkOutput("mflo during busy c1", v, model_lo);
    applyStimulus(C_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
    applyStimulus(C_DIV, 32'd100, 32'd7, 1'b1);
    read_reg(C_MFLO, v);
    checkOutput("mflo during busy c3", v, model_lo);
    wait_complete("mult with ignored ops", 3);

    // mthi on the cycle right after completion
    move_to(C_MTHI, 32'hAAAA_5555);
    check_regs("mthi after completion", model_hi, model_lo);

    // Reset part-way through a div
    issue_arith(C_DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid-op reset busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    check_regs("mid-op reset", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue_arith(C_MULTU, 32'd3, 32'd4);
    wait_complete("multu 3*4 after reset", 5);
    checkOutput("multu 3*4 const LO", model_lo, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
